// File: rtl/data_cache.sv
// Direct-mapped write-back/write-allocate cache, 8 sets x 4 bytes; hits are zero-latency,
// misses stall via cpu_busywait for 4L+1 (clean) or 8L+1 (dirty) cycles of byte transfers.
module data_cache (
  input  logic       clock,
  input  logic       reset,
  input  logic       cpu_read,
  input  logic       cpu_write,
  input  logic [7:0] cpu_address,
  input  logic [7:0] cpu_writedata,
  output logic [7:0] cpu_readdata,
  output logic       cpu_busywait,
  output logic       mem_read,
  output logic       mem_write,
  output logic [7:0] mem_address,
  output logic [7:0] mem_writedata,
  input  logic [7:0] mem_readdata,
  input  logic       mem_busywait
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

  state_t          state;
  logic [7:0]      valid;
  logic [7:0]      dirty;
  logic [2:0]      tag_array  [8];
  logic [3:0][7:0] data_array [8];
  logic [1:0]      count;

  logic [1:0] offset;
  logic [2:0] index;
  logic [2:0] cpu_tag;
  logic       request;
  logic       hit;

  assign offset  = cpu_address[1:0];
  assign index   = cpu_address[4:2];
  assign cpu_tag = cpu_address[7:5];
  assign request = cpu_read ^ cpu_write;
  assign hit     = valid[index] && (tag_array[index] == cpu_tag);

  assign cpu_busywait = !reset && request && ((state != IDLE) || !hit);
  assign cpu_readdata = reset ? 8'h00 : data_array[index][offset];

  // A request is only ever raised from a deasserted cycle, so every byte is preceded by a gap.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      valid         <= '0;
      dirty         <= '0;
      count         <= 2'd0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= 8'h00;
      mem_writedata <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            if (hit) begin
              if (cpu_write) dirty[index] <= 1'b1;
            end else if (valid[index] && dirty[index]) begin
              state         <= WRITEBACK;
              mem_write     <= 1'b1;
              mem_address   <= {tag_array[index], index, 2'd0};
              mem_writedata <= data_array[index][0];
            end else begin
              state       <= FETCH;
              mem_read    <= 1'b1;
              mem_address <= {cpu_tag, index, 2'd0};
            end
          end
        end
        WRITEBACK: begin
          if (mem_write) begin
            if (!mem_busywait) begin
              mem_write <= 1'b0;
              count     <= count + 2'd1;
              if (count == 2'd3) state <= FETCH;
            end
          end else begin
            mem_write     <= 1'b1;
            mem_address   <= {tag_array[index], index, count};
            mem_writedata <= data_array[index][count];
          end
        end
        FETCH: begin
          if (mem_read) begin
            if (!mem_busywait) begin
              mem_read <= 1'b0;
              count    <= count + 2'd1;
              if (count == 2'd3) state <= UPDATE;
            end
          end else begin
            mem_read    <= 1'b1;
            mem_address <= {cpu_tag, index, count};
          end
        end
        UPDATE: begin
          tag_array[index] <= cpu_tag;
          valid[index]     <= 1'b1;
          dirty[index]     <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data storage carries no reset; contents are meaningless until the set is valid.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == IDLE && request && hit && cpu_write)
        data_array[index][offset] <= cpu_writedata;
      else if (state == FETCH && mem_read && !mem_busywait)
        data_array[index][count] <= mem_readdata;
    end
  end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back, write-allocate data cache between the CPU's load/store path and the 256x8 byte-wide `data_memory`. CPU hits complete with no stall. A miss stalls the CPU through `cpu_busywait`, writes back a dirty victim block, then refills the block, one byte per memory access. Geometry is 8 sets x 4-byte blocks (32 bytes total) over the 8-bit address space.

## Interface
- Parameters: none. Geometry is fixed: offset = `address[1:0]`, index = `address[4:2]`, tag = `address[7:5]`.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_read` in 1: CPU load request; held until `cpu_busywait` is 0.
- `cpu_write` in 1: CPU store request; held until `cpu_busywait` is 0.
- `cpu_address` in 8: byte address; held stable while the request is pending.
- `cpu_writedata` in 8: store data.
- `cpu_readdata` out 8: load data; valid while `cpu_read` is asserted and `cpu_busywait` is 0.
- `cpu_busywait` out 1: stall to the CPU.
- `mem_read` out 1: byte read request to `data_memory`.
- `mem_write` out 1: byte write request to `data_memory`.
- `mem_address` out 8: memory byte address.
- `mem_writedata` out 8: write-back byte.
- `mem_readdata` in 8: refill byte.
- `mem_busywait` in 1: memory busy.

## Operation
- Per set: `valid`, `dirty`, 3-bit tag, 4x8 data.
- Hit = `valid & (tag == cpu_address[7:5])`.
- Request = `cpu_read ^ cpu_write`. When `cpu_read` and `cpu_write` are both asserted, the access is ignored: no stall and no state change.
- States:
  - IDLE: no memory request outstanding.
    - Read hit: `cpu_readdata` = byte[offset], combinational, same cycle.
    - Write hit: byte[offset] and `dirty` update at the next edge.
    - Miss with `valid & dirty` goes to WRITEBACK. Any other miss goes to FETCH.
  - WRITEBACK: 4 byte writes of the victim block to `{old_tag, index, k}`, k = 0..3 in order, with `mem_writedata` = byte[k]. After k = 3 completes, go to FETCH.
  - FETCH: 4 byte reads from `{cpu_tag, index, k}`, k = 0..3. `mem_readdata` is stored into byte[k] at each completion edge. After k = 3 completes, go to UPDATE.
  - UPDATE (1 cycle): tag <= cpu tag, `valid` <= 1, `dirty` <= 0, then go to IDLE.
- The original access is replayed in IDLE as a hit. A write miss therefore merges the store after the refill and sets `dirty`.
- `cpu_busywait` = request & (state != IDLE | miss). It is forced to 0 while `reset` is high.
- The CPU must hold address and data constant during a stall. Changing them mid-miss is outside spec.

## Timing
- Byte transfer protocol:
  - Assert exactly one of `mem_read` / `mem_write`, with `mem_address` and `mem_writedata` registered and stable.
  - The transfer completes at the first rising edge where `mem_busywait` is sampled 0, provided the request was asserted during the whole preceding cycle.
  - At that edge the request deasserts for exactly one cycle before the next byte. A gap cycle is mandatory because the memory only detects new accesses on request edges.
  - `mem_read` and `mem_write` are never asserted together.
- Byte address counter: 2 bits, incremented per completed transfer. It wraps 3 -> 0 at the end of each phase, with no carry into the index.
- Miss latency, with L = cycles per memory transfer including the gap:
  - Clean miss: 4L + 1 cycles from detection to hit.
  - Dirty miss: 8L + 1 cycles.
  - Hit: 0 stall cycles.
- Reset (synchronous):
  - At the reset edge, all `valid` and `dirty` bits clear and state returns to IDLE.
  - `mem_read`, `mem_write`, `mem_address`, `mem_writedata`, and the byte counter all go to 0.
  - `cpu_readdata` reads 0 and `cpu_busywait` is 0 while reset is high.
  - Reset during WRITEBACK or FETCH aborts at that edge. Partial refill data is discarded and dirty data is lost.
- Data arrays need not be cleared. They are unobservable while `valid` = 0.

## Test plan
- Cold read miss:
  - Stimulus: after reset, with memory preloaded so mem[a] = a, set `cpu_read`, address 0x25.
  - Required: `cpu_busywait` = 1 in the same cycle; no `mem_write`; 4 `mem_read` at 0x24, 0x25, 0x26, 0x27 with a 1-cycle gap between each; then `cpu_busywait` drops and `cpu_readdata` = 0x25.
- Read hit:
  - Stimulus: next, read 0x26.
  - Required: `cpu_busywait` stays 0, `cpu_readdata` = 0x26 in the same cycle, and `mem_read` and `mem_write` stay 0.
- Write hit:
  - Stimulus: write 0xAB to 0x24, then read 0x24.
  - Required: no memory traffic, and the read returns 0xAB (set 1 is now dirty).
- Dirty eviction:
  - Stimulus: read 0xA4 (index 1, tag 5).
  - Required: 4 `mem_write` to 0x24–0x27 carrying 0xAB, 0x25, 0x26, 0x27; then 4 `mem_read` at 0xA4–0xA7; then `cpu_readdata` = 0xA4.
- Clean write miss:
  - Stimulus: write 0x5C to 0x0B.
  - Required: no write-back; refill from 0x08–0x0B; the store merges; a later eviction of set 2 writes 0x5C back to 0x0B.
- Reset mid-FETCH:
  - Stimulus: assert `reset` for one cycle after the second refill byte.
  - Required: at the next edge `mem_read` = 0 and the cache returns to IDLE; re-reading the same address is a full 4-read miss.
